// File: rtl/countdown_sequencer_if.sv
// rtl/countdown_sequencer_if.sv - sequencer control, counter handshake and status bundle
// Signals:
//   go, abort, repeat_n     : sequence request, cancel, runs per sequence
//   cnt_ready, cnt_q        : downstream counter status (ready while at 0) and value
//   start                   : start request to the downstream counter
//   busy, done, error       : sequencer status
//   runs_done               : completed runs in current/last sequence
// Modports: master drives requests and counter status, slave is the sequencer.
interface countdown_sequencer_if;
  logic       go;
  logic       abort;
  logic [3:0] repeat_n;
  logic       cnt_ready;
  logic [4:0] cnt_q;
  logic       start;
  logic       busy;
  logic       done;
  logic       error;
  logic [3:0] runs_done;

  modport master (
    output go, abort, repeat_n, cnt_ready, cnt_q,
    input  start, busy, done, error, runs_done
  );

  modport slave (
    input  go, abort, repeat_n, cnt_ready, cnt_q,
    output start, busy, done, error, runs_done
  );
endinterface

// File: rtl/countdown_sequencer.sv
// rtl/countdown_sequencer.sv - runs a downstream countdown counter repeat_n times per request
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : countdown_sequencer_if.slave (requests, counter status, registered outputs)
// Parameters:
//   ARM_TO : cycles allowed in ARM for the counter to leave zero
//   RUN_TO : cycles allowed in RUN for the counter to return to zero
module countdown_sequencer #(
  parameter int ARM_TO = 4,
  parameter int RUN_TO = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  countdown_sequencer_if.slave  bus
);

  localparam int TMAX = (ARM_TO > RUN_TO) ? ARM_TO : RUN_TO;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_RUN  = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    remaining_q, remaining_d;
  logic [3:0]    runs_done_q, runs_done_d;
  logic [4:0]    last_q, last_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          start_q, start_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          error_q, error_d;

  // The first RUN cycle compares against the value seen on the last ARM
  // cycle, so last_q tracks cnt_q in every state.
  logic step_bad;
  assign step_bad = (last_q == 5'd0) || (bus.cnt_q != last_q - 5'd1);

  // State register (also holds all datapath and registered outputs)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      runs_done_q <= '0;
      last_q      <= '0;
      tmr_q       <= '0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      runs_done_q <= runs_done_d;
      last_q      <= last_d;
      tmr_q       <= tmr_d;
      start_q     <= start_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    runs_done_d = runs_done_q;
    last_d      = bus.cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.go && !bus.abort) begin
          runs_done_d = '0;
          if (bus.repeat_n == 4'd0) begin
            state_d = S_DONE;
          end else begin
            state_d     = S_ARM;
            remaining_d = bus.repeat_n;
          end
        end
      end
      S_ARM: begin
        if (bus.abort)                          state_d = S_IDLE;
        else if (bus.cnt_q != 5'd0)             state_d = S_RUN;
        else if (tmr_q == TW'(ARM_TO - 1))      state_d = S_ERR;
      end
      S_RUN: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (step_bad) begin
          state_d = S_ERR;
        end else if (bus.cnt_q == 5'd0) begin
          if (bus.cnt_ready) begin
            runs_done_d = (runs_done_q == 4'hf) ? 4'hf : runs_done_q + 4'd1;
            remaining_d = remaining_q - 4'd1;
            state_d     = (remaining_q == 4'd1) ? S_DONE : S_ARM;
          end else begin
            state_d = S_ERR;
          end
        end else if (tmr_q == TW'(RUN_TO - 1)) begin
          state_d = S_ERR;
        end
      end
      S_DONE: state_d = S_IDLE;
      S_ERR: begin
        if (bus.go) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Timeouts restart on every state entry, including RUN -> ARM re-arm.
    if ((state_d == state_q) && ((state_q == S_ARM) || (state_q == S_RUN)))
      tmr_d = tmr_q + TW'(1);
    else
      tmr_d = '0;
  end

  // Output logic: registered outputs decoded from the next state
  always_comb begin
    start_d = (state_d == S_ARM);
    busy_d  = (state_d == S_ARM) || (state_d == S_RUN);
    done_d  = (state_d == S_DONE);
    error_d = (state_d == S_ERR);
  end

  assign bus.start     = start_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.error     = error_q;
  assign bus.runs_done = runs_done_q;

endmodule
